burst_master_spi: RTL and testbench

Parametrised SPI master that runs multi-word bursts to one of `NumSlaves` slaves under a single chip-select assertion. It supports all four CPOL/CPHA modes and MSB- or LSB-first bit order, with a valid/ready transmit handshake and a per-word receive strobe. It is the multi-slave, burst-capable successor to the single-word generic SPI master and sits between a register/DMA front end and the board SPI pins.

---
 rtl/burst_master_spi.sv | 235 +++++++++++++++++++++++
 tb/tb_burst_master_spi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_master_spi.sv
// Multi-slave SPI master: runs bursts of WordLen-bit words under one chip select, all CPOL/CPHA modes.
// Define SPI_LOOPBACK_EN to add LoopEn, which feeds the registered MOSI back into the sampler.
module burst_master_spi #(
   parameter int unsigned SysClk     = 100000000,
   parameter int unsigned SPIClkFreq = 10000000,
   parameter int unsigned WordLen    = 8,
   parameter int unsigned NumSlaves  = 4,
   localparam int unsigned SelW      = (NumSlaves > 1) ? $clog2(NumSlaves) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 CPOL,
   input  logic                 CPHA,
   input  logic                 Endianess,
   input  logic [SelW-1:0]      SlaveSel,
   input  logic [7:0]           BurstLen,
   input  logic                 Start,
   input  logic [WordLen-1:0]   TxData,
   input  logic                 TxValid,
   output logic                 TxReady,
   output logic [WordLen-1:0]   RxData,
   output logic                 RxValid,
   output logic                 Busy,
   output logic                 Done,
   output logic                 SCLK,
   output logic                 MOSI,
`ifdef SPI_LOOPBACK_EN
   input  logic                 LoopEn,
`endif
   input  logic                 MISO,
   output logic [NumSlaves-1:0] SS_n
);

   localparam int unsigned H    = SysClk / (2 * SPIClkFreq);
   localparam int unsigned CntW = (H > 1) ? $clog2(H) : 1;
   localparam int unsigned HpW  = $clog2(2 * WordLen);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, GAP, HOLD} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [HpW-1:0]         hp_q, hp_d;
   logic [7:0]             words_q, words_d;
   logic                   cpol_q, cpol_d, cpha_q, cpha_d, endian_q, endian_d;
   logic [SelW-1:0]        sel_q, sel_d;
   logic [WordLen-1:0]     tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
   logic                   sclk_q, sclk_d, mosi_q, mosi_d;
   logic                   tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [NumSlaves-1:0]   ss_n_q, ss_n_d;
   logic                   half_end_c, sel_ok_c, miso_c;

`ifdef SPI_LOOPBACK_EN
   assign miso_c = LoopEn ? mosi_q : MISO;
`else
   assign miso_c = MISO;
`endif

   function automatic logic head_bit(input logic [WordLen-1:0] w, input logic lsb_first);
      return lsb_first ? w[0] : w[WordLen-1];
   endfunction

   function automatic logic [WordLen-1:0] shift_out(input logic [WordLen-1:0] w, input logic lsb_first);
      return lsb_first ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [WordLen-1:0] shift_in(input logic [WordLen-1:0] w, input logic b,
                                                    input logic lsb_first);
      return lsb_first ? {b, w[WordLen-1:1]} : {w[WordLen-2:0], b};
   endfunction

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hp_q       <= '0;
         words_q    <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         endian_q   <= 1'b0;
         sel_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ss_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hp_q       <= hp_d;
         words_q    <= words_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         endian_q   <= endian_d;
         sel_q      <= sel_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ss_n_q     <= ss_n_d;
      end
   end

   assign half_end_c = (cnt_q == CntW'(H - 1));

   // Next-state, half-period timing and shift logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hp_d       = hp_q;
      words_d    = words_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      endian_d   = endian_q;
      sel_d      = sel_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      sel_ok_c   = 1'b0;
      for (int i = 0; i < NumSlaves; i++) begin
         if (SlaveSel == SelW'(i)) sel_ok_c = 1'b1;
      end

      case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            // a Start coinciding with the Done strobe is dropped
            if (Start && !done_q && sel_ok_c) begin
               cpol_d   = CPOL;
               cpha_d   = CPHA;
               endian_d = Endianess;
               sel_d    = SlaveSel;
               words_d  = BurstLen;
               sclk_d   = CPOL;
               cnt_d    = '0;
               state_d  = SETUP;
            end
         end
         SETUP, GAP: begin
            if (half_end_c) begin
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         LOAD: begin
            if (TxValid && tx_ready_q) begin
               hp_d    = '0;
               cnt_d   = '0;
               state_d = SHIFT;
               if (cpha_q) begin
                  tx_sr_d = TxData;
               end else begin
                  mosi_d  = head_bit(TxData, endian_q);
                  tx_sr_d = shift_out(TxData, endian_q);
               end
            end
         end
         SHIFT: begin
            if (half_end_c) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               // even half-periods end on the leading edge, odd ones on the trailing edge
               if (hp_q[0] == cpha_q) begin
                  rx_sr_d = shift_in(rx_sr_q, miso_c, endian_q);
                  if ((hp_q >> 1) == HpW'(WordLen - 1)) begin
                     rx_data_d  = rx_sr_d;
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  mosi_d  = head_bit(tx_sr_q, endian_q);
                  tx_sr_d = shift_out(tx_sr_q, endian_q);
               end
               if (hp_q == HpW'(2 * WordLen - 1)) begin
                  if (words_q == 8'd0) begin
                     state_d = HOLD;
                  end else begin
                     words_d = words_q - 8'd1;
                     state_d = GAP;
                  end
               end else begin
                  hp_d = hp_q + HpW'(1);
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         HOLD: begin
            if (half_end_c) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      tx_ready_d = (state_d == LOAD);
      busy_d     = (state_d != IDLE);
      ss_n_d     = '1;
      if (state_d != IDLE) begin
         for (int i = 0; i < NumSlaves; i++) begin
            if (sel_d == SelW'(i)) ss_n_d[i] = 1'b0;
         end
      end
   end

   assign TxReady = tx_ready_q;
   assign RxData  = rx_data_q;
   assign RxValid = rx_valid_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign SS_n    = ss_n_q;

endmodule

// File: tb/tb_burst_master_spi.sv
// Directed bench for burst_master_spi: mode-aware SPI slave model plus cycle monitors.
module tb_burst_master_spi;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       CPOL, CPHA, Endianess;
   logic [1:0] SlaveSel;
   logic [7:0] BurstLen;
   logic       Start;
   logic [7:0] TxData;
   logic       TxValid;
   logic       TxReady;
   logic [7:0] RxData;
   logic       RxValid, Busy, Done, SCLK, MOSI;
   logic       MISO = 1'b0;
   logic [3:0] SS_n;
`ifdef SPI_LOOPBACK_EN
   logic       LoopEn = 1'b0;
`endif

   always #5 clk = ~clk;

   burst_master_spi #(
      .SysClk(100000000), .SPIClkFreq(10000000), .WordLen(8), .NumSlaves(4)
   ) dut (
      .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA), .Endianess(Endianess),
      .SlaveSel(SlaveSel), .BurstLen(BurstLen), .Start(Start), .TxData(TxData),
      .TxValid(TxValid), .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid),
      .Busy(Busy), .Done(Done), .SCLK(SCLK), .MOSI(MOSI),
`ifdef SPI_LOOPBACK_EN
      .LoopEn(LoopEn),
`endif
      .MISO(MISO), .SS_n(SS_n)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // slave configuration, written by the stimulus only
   logic       m_cpol = 1'b0, m_cpha = 1'b0, m_endian = 1'b0, tie0 = 1'b0;
   logic [1:0] m_sel = 2'd0;
   logic [7:0] s_tx = 8'h00;
   logic [3:0] exp_ss = 4'hF;
   logic [7:0] exp_rxw = 8'h00;
   int         mon_gen = 0;

   // slave model state
   logic [7:0] s_rx = 8'h00, s_cap = 8'h00;
   int         s_k = 0, s_words = 0, s_nsamp = 0, s_ones = 0;
   logic       s_first = 1'b0, s_prev_act = 1'b0, s_prev_sclk = 1'b0;

   function automatic logic s_bit(input logic [7:0] w, input int k, input logic lsb);
      logic [7:0] t;
      t = w;
      return lsb ? t[k] : t[7 - k];
   endfunction

   always @(negedge clk) begin : slave_model
      logic act, lead;
      act = !SS_n[m_sel];
      if (act && !s_prev_act) begin
         s_k = 0; s_words = 0; s_nsamp = 0; s_ones = 0; s_first = 1'b0;
         MISO = tie0 ? 1'b0 : s_bit(s_tx, 0, m_endian);
      end else if (act && SCLK != s_prev_sclk) begin
         lead = (SCLK != m_cpol);
         if (lead != m_cpha) begin
            s_rx = m_endian ? {MOSI, s_rx[7:1]} : {s_rx[6:0], MOSI};
            if (s_nsamp == 0) s_first = MOSI;
            if (s_nsamp < 8) s_ones += int'(MOSI);
            s_nsamp++;
            if (m_cpha) begin
               s_k++;
               if (s_k == 8) begin s_k = 0; s_cap = s_rx; s_words++; end
            end
         end else begin
            if (!m_cpha) begin
               s_k++;
               if (s_k == 8) begin s_k = 0; s_cap = s_rx; s_words++; end
            end
            MISO = tie0 ? 1'b0 : s_bit(s_tx, s_k, m_endian);
         end
      end
      s_prev_act  = act;
      s_prev_sclk = SCLK;
   end

   // per-burst monitor counters
   int         seen_gen = 0;
   int         busy_cnt, ss_cnt, ss_bad, sclk_bad, rxv_cnt, rx_bad, first_rxv, done_cnt, done_bad;
   logic [7:0] rx_last;

   always @(negedge clk) begin
      if (mon_gen != seen_gen) begin
         seen_gen = mon_gen;
         busy_cnt = 0; ss_cnt = 0; ss_bad = 0; sclk_bad = 0; rxv_cnt = 0;
         rx_bad = 0; first_rxv = 0; done_cnt = 0; done_bad = 0; rx_last = 8'h00;
      end
      if (Busy) begin
         busy_cnt++;
         if (SS_n == exp_ss) ss_cnt++; else ss_bad++;
         if (TxReady && SCLK !== m_cpol) sclk_bad++;
      end else if (reset && SS_n != 4'hF) begin
         ss_bad++;
      end
      if (RxValid) begin
         rxv_cnt++;
         rx_last = RxData;
         if (RxData !== exp_rxw) rx_bad++;
         if (rxv_cnt == 1) first_rxv = busy_cnt;
      end
      if (Done) begin
         done_cnt++;
         if (Busy || SS_n != 4'hF) done_bad++;
      end
   end

   task automatic run_burst(input string name, input logic cpol, input logic cpha, input logic endian,
                            input logic [1:0] sel, input logic [7:0] blen, input logic [7:0] txd,
                            input logic [7:0] stx, input logic [7:0] exp_rx,
                            input int stall_word, input int stall_cyc);
      int n, exp_busy, cyc, words;
      bit stalled;
      n        = int'(blen) + 1;
      exp_busy = int'(H) + n * (1 + 2 * int'(W * H)) + (n - 1) * int'(H) + int'(H)
                 + ((stall_word >= 0) ? stall_cyc : 0);
      m_cpol = cpol; m_cpha = cpha; m_endian = endian; m_sel = sel; s_tx = stx;
      exp_ss = ~(4'b0001 << sel); exp_rxw = exp_rx;
      mon_gen++;
      @(negedge clk);
      CPOL = cpol; CPHA = cpha; Endianess = endian; SlaveSel = sel; BurstLen = blen;
      TxData = txd; TxValid = 1'b1; Start = 1'b1;
      @(negedge clk);
      // scramble configuration inputs: the burst must use the latched copy
      Start = 1'b0; CPOL = ~cpol; CPHA = ~cpha; Endianess = ~endian; SlaveSel = ~sel; BurstLen = ~blen;
      cyc = 0; words = 0; stalled = 0;
      while (done_cnt == 0 && cyc < 5000) begin
         if (TxReady && !stalled && words == stall_word) begin
            TxValid = 1'b0;
            repeat (stall_cyc) @(negedge clk);
            cyc += stall_cyc;
            TxValid = 1'b1;
            stalled = 1;
         end
         if (TxReady && TxValid) words++;
         @(negedge clk);
         cyc++;
      end
      TxValid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq({name, ".done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({name, ".done_edge"}, 32'(done_bad), 32'd0);
      check_eq({name, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check_eq({name, ".ss_cycles"}, 32'(ss_cnt), 32'(exp_busy));
      check_eq({name, ".ss_bad"}, 32'(ss_bad), 32'd0);
      check_eq({name, ".sclk_idle_load"}, 32'(sclk_bad), 32'd0);
      check_eq({name, ".sclk_idle_end"}, 32'(SCLK), 32'(cpol));
      check_eq({name, ".rxvalid_cnt"}, 32'(rxv_cnt), 32'(n));
      check_eq({name, ".rxdata_bad"}, 32'(rx_bad), 32'd0);
      check_eq({name, ".rxdata"}, 32'(rx_last), 32'(exp_rx));
      check_eq({name, ".rxvalid_pos"}, 32'(first_rxv), cpha ? 32'd87 : 32'd82);
      check_eq({name, ".slave_words"}, 32'(s_words), 32'(n));
      check_eq({name, ".mosi_word"}, 32'(s_cap), 32'(txd));
   endtask

   initial begin
      int words, cyc;
      reset = 1'b0; Start = 1'b0; TxValid = 1'b0; TxData = 8'h00; CPOL = 1'b0; CPHA = 1'b0;
      Endianess = 1'b0; SlaveSel = 2'd0; BurstLen = 8'd0;
      repeat (3) @(negedge clk);
      check_eq("rst.ss_n", 32'(SS_n), 32'hF);
      check_eq("rst.sclk", 32'(SCLK), 32'd0);
      check_eq("rst.mosi", 32'(MOSI), 32'd0);
      check_eq("rst.txready", 32'(TxReady), 32'd0);
      check_eq("rst.rxvalid", 32'(RxValid), 32'd0);
      check_eq("rst.busy", 32'(Busy), 32'd0);
      check_eq("rst.done", 32'(Done), 32'd0);
      check_eq("rst.rxdata", 32'(RxData), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_burst("mode0_a5", 1'b0, 1'b0, 1'b0, 2'd2, 8'd0, 8'hA5, 8'h3C, 8'h3C, -1, 0);
      for (int m = 0; m < 4; m++) begin
         run_burst($sformatf("mode%0d", m), m[1], m[0], 1'b0, 2'(m), 8'd0, 8'h81, 8'h6B, 8'h6B, -1, 0);
      end
      run_burst("stall", 1'b0, 1'b0, 1'b0, 2'd1, 8'd3, 8'h96, 8'hC3, 8'hC3, 2, 20);
      run_burst("lsb", 1'b0, 1'b0, 1'b1, 2'd0, 8'd0, 8'h01, 8'h80, 8'h80, -1, 0);
      check_eq("lsb.first_bit", 32'(s_first), 32'd1);
      check_eq("lsb.ones", 32'(s_ones), 32'd1);
      run_burst("lsb_m3", 1'b1, 1'b1, 1'b1, 2'd3, 8'd1, 8'h2D, 8'hB4, 8'hB4, -1, 0);

      // reset in the middle of word 2 of a 4-word burst
      m_cpol = 1'b1; m_cpha = 1'b0; m_endian = 1'b0; m_sel = 2'd1; s_tx = 8'h55;
      exp_ss = 4'b1101; exp_rxw = 8'h55;
      mon_gen++;
      @(negedge clk);
      CPOL = 1'b1; CPHA = 1'b0; Endianess = 1'b0; SlaveSel = 2'd1; BurstLen = 8'd3;
      TxData = 8'h33; TxValid = 1'b1; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      words = 0; cyc = 0;
      while (words < 2 && cyc < 2000) begin
         if (TxReady && TxValid) words++;
         @(negedge clk);
         cyc++;
      end
      repeat (10) @(negedge clk);
      check_eq("abort.busy_before", 32'(Busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check_eq("abort.ss_n", 32'(SS_n), 32'hF);
      check_eq("abort.sclk", 32'(SCLK), 32'd0);
      check_eq("abort.busy", 32'(Busy), 32'd0);
      check_eq("abort.done", 32'(Done), 32'd0);
      check_eq("abort.txready", 32'(TxReady), 32'd0);
      TxValid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("abort.no_done", 32'(done_cnt), 32'd0);
      run_burst("after_abort", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'h5A, 8'hE1, 8'hE1, -1, 0);

`ifdef SPI_LOOPBACK_EN
      tie0 = 1'b1;
      LoopEn = 1'b1;
      run_burst("loop_00", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 8'h00, -1, 0);
      run_burst("loop_ff", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'hFF, 8'h00, 8'hFF, -1, 0);
      run_burst("loop_5a", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'h5A, 8'h00, 8'h5A, -1, 0);
      LoopEn = 1'b0;
      tie0 = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
